layer_seq_ctrl: RTL and testbench

- Top-level layer sequencer for the LeNet datapath.
- Launches the per-layer controllers (conv1, pool1, conv2, pool2, fc) in order, using each one's start pulse / done pulse handshake.
- Tracks the active layer, guards each layer with a watchdog, reports network completion and errors, and counts processed frames.

---
 rtl/layer_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_layer_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
// Layer sequencer for the LeNet datapath: launches each layer controller in order via
// start/done handshakes, guards every layer with a watchdog and counts completed passes.
module layer_seq_ctrl #(
    parameter int NUM_LAYERS = 5,
    parameter int TO_W       = 16,
    parameter int TIMEOUT    = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  net_start,
    input  logic                  net_abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [2:0]            layer_idx,
    output logic                  busy,
    output logic                  net_done,
    output logic                  timeout_err,
    output logic [7:0]            frame_cnt
);

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        LAUNCH = 6'b000010,
        WAIT   = 6'b000100,
        NEXT   = 6'b001000,
        DONE   = 6'b010000,
        ERR    = 6'b100000
    } state_t;

    localparam logic [2:0]      LAST_IDX = 3'(NUM_LAYERS - 1);
    localparam logic [TO_W-1:0] WD_MAX   = TO_W'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [2:0]      idx_nx;
    logic [TO_W-1:0] wdog, wdog_nx;
    logic [7:0]      fcnt_nx;
    logic            terr_nx;
    logic            done_sel;

    // Only the done bit of the active layer is honoured.
    always_comb begin
        done_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (layer_idx == 3'(i)) begin
                done_sel = layer_done[i];
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = layer_idx;
        wdog_nx  = wdog;
        fcnt_nx  = frame_cnt;
        terr_nx  = timeout_err;
        if (net_abort) begin
            state_nx = IDLE;
            idx_nx   = '0;
            wdog_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (net_start) begin
                        state_nx = LAUNCH;
                        idx_nx   = '0;
                        terr_nx  = 1'b0;
                    end
                end
                LAUNCH: begin
                    wdog_nx  = '0;
                    state_nx = WAIT;
                end
                WAIT: begin
                    // A done on the expiry cycle takes precedence over the timeout.
                    if (done_sel) begin
                        if (layer_idx == LAST_IDX) begin
                            state_nx = DONE;
                            fcnt_nx  = frame_cnt + 8'd1;
                        end else begin
                            state_nx = NEXT;
                        end
                    end else if (wdog == WD_MAX) begin
                        state_nx = ERR;
                        terr_nx  = 1'b1;
                    end else begin
                        wdog_nx = wdog + TO_W'(1);
                    end
                end
                NEXT: begin
                    idx_nx   = layer_idx + 3'd1;
                    state_nx = LAUNCH;
                end
                DONE: begin
                    idx_nx   = '0;
                    state_nx = IDLE;
                end
                ERR: begin
                    state_nx = ERR;
                end
                default: begin
                    idx_nx   = '0;
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx   <= '0;
            wdog        <= '0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            layer_idx   <= idx_nx;
            wdog        <= wdog_nx;
            frame_cnt   <= fcnt_nx;
            timeout_err <= terr_nx;
        end
    end

    always_comb begin
        layer_start = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            layer_start[i] = (state == LAUNCH) && (layer_idx == 3'(i));
        end
        busy     = (state != IDLE);
        net_done = (state == DONE);
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Randomized bench for layer_seq_ctrl: per-pass event schedule computed from per-layer
// done delays, compared against the DUT outputs every cycle.
module tb_layer_seq_ctrl;

    localparam int NL  = 5;
    localparam int TW  = 8;
    localparam int TMO = 24;
    localparam int VW  = NL + 14;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          net_start;
    logic          net_abort;
    logic [NL-1:0] layer_done;
    logic [NL-1:0] layer_start;
    logic [2:0]    layer_idx;
    logic          busy;
    logic          net_done;
    logic          timeout_err;
    logic [7:0]    frame_cnt;

    layer_seq_ctrl #(.NUM_LAYERS(NL), .TO_W(TW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .net_start(net_start), .net_abort(net_abort),
        .layer_done(layer_done), .layer_start(layer_start), .layer_idx(layer_idx),
        .busy(busy), .net_done(net_done), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int m_fc  = 0;
    bit m_terr = 1'b0;
    int d_cfg[NL];

    // d_cfg[i] = WAIT cycle (1-based) on which layer i answers; > TMO means it never does.
    // Step k drives inputs sampled at edge k and checks the outputs right after that edge.
    task automatic run_pass(input string name, input int abort_in, input bit spur);
        int s[NL+1];
        int dstep[NL];
        int idx_a[512];
        logic [VW-1:0] exp_v[512];
        int err_at, err_layer, n, natural, idle_from, abort_at, hz, top;
        bit hang, completes, err_active, accepted;
        logic [NL-1:0] e_st, ld;
        logic [2:0] e_idx;
        logic e_busy, e_done, e_terr;
        logic [7:0] e_fc;
        logic [VW-1:0] act;

        abort_at = abort_in; hang = 0; err_at = -1; err_layer = 0; n = -1;
        for (int i = 0; i <= NL; i++) s[i] = BIG;
        s[0] = 0;
        for (int i = 0; i < NL; i++) begin
            dstep[i] = -1;
            if (!hang) begin
                if (d_cfg[i] <= TMO) begin
                    dstep[i] = s[i] + d_cfg[i] + 1;
                    s[i+1]   = s[i] + d_cfg[i] + 2;
                end else begin
                    hang = 1; err_layer = i; err_at = s[i] + TMO + 1;
                end
            end
        end
        if (hang) begin
            natural = BIG;
            if (abort_at < 0) abort_at = err_at + 4;
            top = err_layer;
        end else begin
            n = s[NL] - 1;
            natural = n + 1;
            top = NL - 1;
        end
        idle_from  = (abort_at >= 0 && abort_at < natural) ? abort_at : natural;
        completes  = !hang && idle_from > n;
        err_active = hang && idle_from > err_at;
        accepted   = idle_from > 0;
        hz = idle_from + 2;

        for (int k = 0; k <= hz; k++) begin
            e_st = '0; e_idx = '0; e_busy = 0; e_done = 0;
            if (k < idle_from) begin
                e_busy = 1;
                if (err_active && k >= err_at) begin
                    e_idx = 3'(err_layer);
                end else if (completes && k == n) begin
                    e_idx = 3'(NL - 1); e_done = 1;
                end else begin
                    for (int i = 0; i <= top; i++) if (s[i] <= k) e_idx = 3'(i);
                    if (k == s[e_idx]) e_st[e_idx] = 1'b1;
                end
            end
            e_terr = accepted ? (err_active && k >= err_at) : m_terr;
            e_fc = 8'(m_fc + ((completes && k >= n) ? 1 : 0));
            exp_v[k] = {e_st, e_idx, e_busy, e_done, e_terr, e_fc};
            idx_a[k] = int'(e_idx);
        end

        for (int k = 0; k <= hz; k++) begin
            net_start = (k == 0) || (spur && k >= 1 && k <= idle_from && $urandom_range(0, 3) == 0);
            net_abort = (k == abort_at);
            ld = '0;
            if (spur) begin
                ld = NL'($urandom);
                if (k >= 1) ld[idx_a[k-1]] = 1'b0;
                for (int i = 0; i <= top; i++) if (k >= 1 && k - 1 == s[i]) ld[i] = 1'b1;
            end
            for (int i = 0; i < NL; i++) if (dstep[i] == k && k <= idle_from) ld[i] = 1'b1;
            layer_done = ld;
            @(posedge clk);
            @(negedge clk);
            act = {layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt};
            tests++;
            if (act !== exp_v[k]) begin
                fails++;
                $display("FAIL %s step %0d: got start/idx/busy/done/terr/fcnt=%b/%0d/%b/%b/%b/%0d want %b/%0d/%b/%b/%b/%0d",
                         name, k, act[VW-1 -: NL], act[13:11], act[10], act[9], act[8], act[7:0],
                         exp_v[k][VW-1 -: NL], exp_v[k][13:11], exp_v[k][10], exp_v[k][9],
                         exp_v[k][8], exp_v[k][7:0]);
            end
        end
        net_start = 0; net_abort = 0; layer_done = '0;
        m_fc = (m_fc + (completes ? 1 : 0)) % 256;
        if (accepted) m_terr = err_active;
    endtask

    task automatic rand_delays(input int max_d);
        for (int i = 0; i < NL; i++) d_cfg[i] = $urandom_range(1, max_d);
    endtask

    task automatic test_reset;
        rst_n = 0; net_start = 0; net_abort = 0; layer_done = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_hold: got %b want all zero",
                     {layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt});
        end
        rst_n = 1;
        repeat (8) @(negedge clk);
        tests++;
        if ({layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_release: got %b want all zero",
                     {layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt});
        end
    endtask

    task automatic test_nominal;
        for (int i = 0; i < NL; i++) d_cfg[i] = 20;
        run_pass("nominal", -1, 0);
    endtask

    task automatic test_watchdog;
        rand_delays(TMO);
        d_cfg[2] = TMO + 1;
        run_pass("watchdog", -1, 0);
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL watchdog_sticky: got timeout_err=%b want 1", timeout_err);
        end
        rand_delays(TMO);
        run_pass("restart", -1, 0);
    endtask

    task automatic test_abort;
        rand_delays(TMO);
        run_pass("abort_with_done1", d_cfg[0] + d_cfg[1] + 3, 0);
        rand_delays(TMO);
        run_pass("abort_mid", $urandom_range(1, 40), 0);
    endtask

    task automatic test_spurious;
        for (int r = 0; r < 3; r++) begin
            rand_delays(TMO);
            run_pass("spurious", -1, 1);
        end
    endtask

    task automatic test_race;
        for (int i = 0; i < NL; i++) d_cfg[i] = TMO;
        run_pass("race_all", -1, 0);
        rand_delays(TMO);
        d_cfg[$urandom_range(0, NL - 1)] = TMO;
        run_pass("race_one", -1, 1);
    endtask

    task automatic test_random;
        for (int r = 0; r < 30; r++) begin
            rand_delays(TMO);
            if ($urandom_range(0, 9) == 0) d_cfg[$urandom_range(0, NL - 1)] = TMO + 1;
            run_pass("random", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 100)) : -1,
                     1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_wait;
        net_start = 1;
        @(posedge clk);
        @(negedge clk);
        net_start = 0;
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        tests++;
        if ({layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_async: got %b want all zero",
                     {layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt});
        end
        @(negedge clk);
        rst_n = 1;
        m_fc = 0; m_terr = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_after: got %b want all zero",
                     {layer_start, layer_idx, busy, net_done, timeout_err, frame_cnt});
        end
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 256; r++) begin
            rand_delays(3);
            run_pass("wrap", -1, 0);
        end
        tests++;
        if (frame_cnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap_final: got frame_cnt=%0d want 0", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        repeat (8) @(negedge clk);
        test_nominal();
        test_watchdog();
        test_abort();
        test_spurious();
        test_race();
        test_random();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
